// File: rtl/noc_ep_bridge.sv
// rtl/noc_ep_bridge.sv - NoC endpoint bridge: flit-to-word RX reassembly and word-to-byte TX serialiser
// Optional feature macro: NOC_EP_DEST_FILTER_EN (destination id filter with drop counter)
module noc_ep_bridge #(
    parameter logic [3:0] NODE_ID    = 4'd0,
    parameter int         GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] f_a,
    output logic [8:0]  to_a,
    output logic [31:0] rx_data,
    output logic [3:0]  rx_id,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    // ---------------- RX path ----------------
    logic [31:0] asm_q;
    logic [1:0]  cnt_q;
    logic [3:0]  fid_q;
    logic        id_match;
    logic        accept;
    logic        drop;
    logic        complete;
    logic        drain;

    assign id_match = (f_a[11:8] == NODE_ID);

`ifdef NOC_EP_DEST_FILTER_EN
    assign accept = f_a[16] && id_match;
    assign drop   = f_a[16] && !id_match;
`else
    assign accept = f_a[16];
    assign drop   = 1'b0;
`endif

    assign complete = accept && (cnt_q == 2'd3);
    assign drain    = rx_valid && rx_ready;

    // Shift accepted bytes in MSB first; latch the id of each frame's first flit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= 32'd0;
            cnt_q <= 2'd0;
            fid_q <= 4'd0;
        end else if (accept) begin
            asm_q <= {asm_q[23:0], f_a[7:0]};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
                fid_q <= f_a[11:8];
            end
        end
    end

    // Holding register: load a finished word when free or being drained this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= 32'd0;
            rx_id    <= 4'd0;
            rx_valid <= 1'b0;
        end else if (complete && (!rx_valid || drain)) begin
            rx_data  <= {asm_q[23:0], f_a[7:0]};
            rx_id    <= fid_q;
            rx_valid <= 1'b1;
        end else if (drain) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky overflow: a lost word wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (complete && rx_valid && !rx_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef NOC_EP_DEST_FILTER_EN
    // Saturating count of flits rejected by the destination filter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, f_a[15:12]};
`else
    assign drop_cnt = 8'd0;

    logic unused_bits;
    assign unused_bits = &{1'b0, f_a[15:12], id_match, drop};
`endif

    // ---------------- TX path ----------------
    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [31:0] buf_q;
    logic [1:0]  idx_q;
    logic [2:0]  gap_q;
    logic        ready_en_q;

    assign tx_ready = ready_en_q && (state_q == IDLE);
    assign to_a     = (state_q == SEND) ? {1'b1, buf_q[31:24]} : 9'd0;

    // TX state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX next-state: IDLE -> SEND (4 bytes) -> GAP (GAP_CYCLES) -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tx_valid && tx_ready) state_d = SEND;
            SEND: if (idx_q == 2'd3) state_d = GAP;
            GAP:  if (gap_q == 3'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // TX datapath: word latch, byte shifter, byte index and gap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q      <= 32'd0;
            idx_q      <= 2'd0;
            gap_q      <= 3'd0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        buf_q <= tx_data;
                        idx_q <= 2'd0;
                    end
                end
                SEND: begin
                    buf_q <= {buf_q[23:0], 8'd0};
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        gap_q <= GAP_LAST;
                    end
                end
                GAP: begin
                    if (gap_q != 3'd0) begin
                        gap_q <= gap_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_ep_bridge.sv
// tb/tb_noc_ep_bridge.sv - scoreboard testbench for noc_ep_bridge
module tb_noc_ep_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] f_a;
    logic [8:0]  to_a;
    logic [31:0] rx_data;
    logic [3:0]  rx_id;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [35:0] rx_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    noc_ep_bridge #(.NODE_ID(4'd5), .GAP_CYCLES(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_a      (f_a),
        .to_a     (to_a),
        .rx_data  (rx_data),
        .rx_id    (rx_id),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] idf(input logic [3:0] x);
`ifdef NOC_EP_DEST_FILTER_EN
        return 4'd5;
`else
        return x;
`endif
    endfunction

    // RX monitor: every word handshake is checked against the scoreboard
    initial forever begin
        @(negedge clk);
        #1;
        if (rst && rx_valid && rx_ready) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %h expected none", {rx_id, rx_data});
            end else begin
                chk("rx_word", {rx_id, rx_data}, rx_q.pop_front());
            end
        end
    end

    // TX monitor: every valid byte on to_a is checked against the scoreboard
    initial forever begin
        @(negedge clk);
        #1;
        if (to_a[8]) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h expected none", to_a);
            end else begin
                chk("tx_byte", {27'd0, to_a}, {28'd1, tx_q.pop_front()});
            end
        end
    end

    task automatic flit(input logic v, input logic [3:0] id, input logic [7:0] b);
        @(negedge clk);
        f_a = {v, 4'h0, id, b};
    endtask

    // Four valid flits, later flits carry a different id; ends one cycle after the 4th flit
    task automatic frame(input logic [31:0] w, input logic [3:0] id);
        for (int i = 0; i < 4; i++) begin
            flit(1'b1, (i == 0) ? idf(id) : idf(~id), w[31-8*i -: 8]);
        end
        @(negedge clk);
        f_a = '0;
    endtask

    // Handshake one word; returns at the negedge of the first cycle after the handshake
    task automatic tx_word(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", {35'd0, tx_ready}, 36'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        f_a      = '0;
        rx_ready = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        ovf_clr  = 1'b0;
        #1;
        chk("rst_to_a",     {27'd0, to_a},     36'd0);
        chk("rst_rx_valid", {35'd0, rx_valid}, 36'd0);
        chk("rst_rx_data",  {4'd0, rx_data},   36'd0);
        chk("rst_rx_id",    {32'd0, rx_id},    36'd0);
        chk("rst_tx_ready", {35'd0, tx_ready}, 36'd0);
        chk("rst_ovf",      {35'd0, ovf},      36'd0);
        chk("rst_drop_cnt", {28'd0, drop_cnt}, 36'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("tx_ready_before_edge", {35'd0, tx_ready}, 36'd0);
        @(negedge clk);
        chk("tx_ready_after_edge", {35'd0, tx_ready}, 36'd1);

        // Basic reassembly with one-cycle latency and single-cycle valid
        rx_q.push_back({idf(4'd3), 32'hDEADBEEF});
        frame(32'hDEADBEEF, 4'd3);
        chk("rx_latency", {35'd0, rx_valid}, 36'd1);
        @(negedge clk);
        chk("rx_one_cycle", {35'd0, rx_valid}, 36'd0);

        // TX word timing: 4 bytes, 1 gap cycle, ready again after 6 cycles
        tx_q.push_back(8'h12); tx_q.push_back(8'h34);
        tx_q.push_back(8'h56); tx_q.push_back(8'h78);
        tx_word(32'h12345678);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            chk("tx_period_ready", {35'd0, tx_ready}, {35'd0, (k == 6)});
            if (k == 5) chk("tx_gap_idle", {27'd0, to_a}, 36'd0);
        end

        // Overflow: holding register kept, second word lost
        rx_ready = 1'b0;
        rx_q.push_back({idf(4'd1), 32'h11223344});
        frame(32'h11223344, 4'd1);
        frame(32'h55667788, 4'd2);
        chk("ovf_set",      {35'd0, ovf},      36'd1);
        chk("ovf_hold_val", {35'd0, rx_valid}, 36'd1);
        chk("ovf_hold_data", {rx_id, rx_data}, {idf(4'd1), 32'h11223344});
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {35'd0, ovf}, 36'd0);
        ovf_clr = 1'b1;
        frame(32'h99AABBCC, 4'd6);
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", {35'd0, ovf}, 36'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr2", {35'd0, ovf}, 36'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("rx_drained", {35'd0, rx_valid}, 36'd0);

        // Interleaved invalid flits alongside a zero TX word
        rx_q.push_back({idf(4'd7), 32'hCAFEBABE});
        for (int i = 0; i < 4; i++) tx_q.push_back(8'h00);
        fork
            begin
                flit(1'b1, idf(4'd7), 8'hCA);
                flit(1'b0, 4'd7, 8'h99);
                flit(1'b1, idf(4'd1), 8'hFE);
                flit(1'b0, 4'd0, 8'h77);
                flit(1'b0, 4'd0, 8'h55);
                flit(1'b1, idf(4'd1), 8'hBA);
                flit(1'b1, idf(4'd1), 8'hBE);
                @(negedge clk);
                f_a = '0;
            end
            tx_word(32'h00000000);
        join
        repeat (8) @(negedge clk);

        // Reset mid-frame and mid-word
        flit(1'b1, idf(4'd4), 8'hAA);
        flit(1'b1, idf(4'd4), 8'hBB);
        @(negedge clk);
        f_a = '0;
        tx_q.push_back(8'hA1); tx_q.push_back(8'hA2);
        tx_word(32'hA1A2A3A4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("mid_rst_to_a",     {27'd0, to_a},     36'd0);
        chk("mid_rst_rx_valid", {35'd0, rx_valid}, 36'd0);
        chk("mid_rst_rx_data",  {4'd0, rx_data},   36'd0);
        chk("mid_rst_rx_id",    {32'd0, rx_id},    36'd0);
        chk("mid_rst_tx_ready", {35'd0, tx_ready}, 36'd0);
        chk("mid_rst_ovf",      {35'd0, ovf},      36'd0);
        @(negedge clk);
        rst = 1'b1;
        rx_q.push_back({idf(4'd9), 32'h01020304});
        frame(32'h01020304, 4'd9);
        repeat (6) @(negedge clk);

        // Destination filter
`ifdef NOC_EP_DEST_FILTER_EN
        for (int i = 0; i < 4; i++) flit(1'b1, 4'd2, 8'hA1 + 8'(i));
        @(negedge clk);
        f_a = '0;
        chk("drop_cnt_4", {28'd0, drop_cnt}, 36'd4);
        chk("drop_no_valid", {35'd0, rx_valid}, 36'd0);
        for (int i = 0; i < 260; i++) flit(1'b1, 4'd2, 8'h33);
        @(negedge clk);
        f_a = '0;
        chk("drop_cnt_sat", {28'd0, drop_cnt}, 36'd255);
`else
        rx_q.push_back({4'd2, 32'hA1A2A3A4});
        for (int i = 0; i < 4; i++) flit(1'b1, 4'd2, 8'hA1 + 8'(i));
        @(negedge clk);
        f_a = '0;
        chk("nofilter_valid", {35'd0, rx_valid}, 36'd1);
        chk("nofilter_drop_cnt", {28'd0, drop_cnt}, 36'd0);
`endif

        repeat (10) @(negedge clk);
        chk("rx_scoreboard_empty", 36'(rx_q.size()), 36'd0);
        chk("tx_scoreboard_empty", 36'(tx_q.size()), 36'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
